// File: rtl/xbar_pkg.sv
// Shared sizing helpers for the crossbar: index and mux-select widths derived
// from the master count, used by the slave arbiter and the slave-side mux.
package xbar_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Mux select reserves code 0 for "no owner", so it encodes NUM_MASTERS+1 values.
  function automatic int sel_width(input int n);
    return clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/slave_arbiter_rr_pick.sv
// Combinational round-robin selector: scans the request vector upward from the
// start index with wrap-around and reports the first requester found.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int k;
    k   = 0;
    vld = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (!vld && req[k]) begin
        vld = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/slave_arbiter.sv
// Per-slave arbiter: owner register plus round-robin pointer, with lock-aware
// hold/handover. Outputs decode only from the owner register.
module slave_arbiter
  import xbar_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int SEL_W       = sel_width(NUM_MASTERS),
  localparam int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [NUM_MASTERS-1:0] i_Req,
  input  logic [NUM_MASTERS-1:0] i_Lock,
  output logic [NUM_MASTERS-1:0] o_Gnt,
  output logic [SEL_W-1:0]       o_MuxSel
);

  logic                   owner_vld, owner_vld_nxt;
  logic [IDX_W-1:0]       owner_idx, owner_idx_nxt;
  logic [IDX_W-1:0]       ptr, ptr_nxt;
  logic [NUM_MASTERS-1:0] cand;
  logic                   pick_vld;
  logic [IDX_W-1:0]       pick_idx;
  logic                   owner_req, owner_lock;
  logic                   take_new;

  // The current owner is masked out so a handover always goes to someone else.
  always_comb begin
    cand = i_Req;
    if (owner_vld) cand[owner_idx] = 1'b0;
  end

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (cand),
    .start (ptr),
    .vld   (pick_vld),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_req     = i_Req[owner_idx];
    owner_lock    = i_Lock[owner_idx];
    owner_vld_nxt = owner_vld;
    owner_idx_nxt = owner_idx;
    take_new      = 1'b0;
    if (!owner_vld || !owner_req) begin
      // Idle, or owner releasing: pass straight to the next requester, if any.
      owner_vld_nxt = pick_vld;
      take_new      = pick_vld;
    end else if (!owner_lock && pick_vld) begin
      owner_vld_nxt = 1'b1;
      take_new      = 1'b1;
    end
    if (take_new) owner_idx_nxt = pick_idx;
  end

  always_comb begin
    ptr_nxt = ptr;
    if (take_new) begin
      if (pick_idx == IDX_W'(NUM_MASTERS - 1)) ptr_nxt = '0;
      else                                     ptr_nxt = pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      owner_vld <= 1'b0;
      owner_idx <= '0;
      ptr       <= '0;
    end else begin
      owner_vld <= owner_vld_nxt;
      owner_idx <= owner_idx_nxt;
      ptr       <= ptr_nxt;
    end
  end

  always_comb begin
    o_Gnt    = '0;
    o_MuxSel = '0;
    if (owner_vld) begin
      o_Gnt[owner_idx] = 1'b1;
      o_MuxSel         = SEL_W'(owner_idx) + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_slave_arbiter.sv
// Directed bench for slave_arbiter with two masters: expected grant/select
// pairs are queued as each step is driven and checked after the clock edge.
module tb_slave_arbiter;
  import xbar_pkg::*;

  localparam int N  = 2;
  localparam int SW = sel_width(N);
  localparam int W  = N + SW;

  logic          r_Clk = 1'b0;
  logic          r_Rst;
  logic [N-1:0]  r_Req;
  logic [N-1:0]  r_Lock;
  logic [N-1:0]  w_Gnt;
  logic [SW-1:0] w_MuxSel;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 r_Clk = ~r_Clk;

  slave_arbiter #(.NUM_MASTERS(N)) dut (
    .i_Clk    (r_Clk),
    .i_Rst    (r_Rst),
    .i_Req    (r_Req),
    .i_Lock   (r_Lock),
    .o_Gnt    (w_Gnt),
    .o_MuxSel (w_MuxSel)
  );

  function automatic logic [SW-1:0] enc(input logic [N-1:0] g);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) if (g[i]) s = SW'(i + 1);
    return s;
  endfunction

  task automatic push_exp(input logic [N-1:0] g);
    exp_q.push_back({g, enc(g)});
  endtask

  task automatic check_out(input string tag);
    logic [W-1:0]  e;
    logic [N-1:0]  eg;
    logic [SW-1:0] es;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      eg = e[W-1:SW];
      es = e[SW-1:0];
      checks++;
      assert (w_Gnt === eg) else begin
        errors++;
        $error("FAIL %s gnt observed %b expected %b", tag, w_Gnt, eg);
      end
      checks++;
      assert (w_MuxSel === es) else begin
        errors++;
        $error("FAIL %s muxsel observed %0d expected %0d", tag, w_MuxSel, es);
      end
    end
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] lock,
                      input logic [N-1:0] exp_gnt, input string tag);
    r_Req  = req;
    r_Lock = lock;
    push_exp(exp_gnt);
    @(posedge r_Clk);
    #1;
    check_out(tag);
  endtask

  // Raise reset mid-cycle, check the grant drops with no edge, hold it across one edge.
  task automatic reset_pulse(input string tag);
    r_Rst = 1'b1;
    #1;
    push_exp('0);
    check_out({tag, "_async"});
    @(posedge r_Clk);
    #1;
    push_exp('0);
    check_out({tag, "_held"});
    r_Rst = 1'b0;
  endtask

  initial begin
    r_Rst  = 1'b1;
    r_Req  = '0;
    r_Lock = '0;
    #1;
    push_exp('0);
    check_out("reset_no_edge");
    @(posedge r_Clk);
    #1;
    r_Rst = 1'b0;

    step(2'b00, 2'b00, 2'b00, "idle");
    step(2'b11, 2'b00, 2'b01, "simul_start");
    for (int i = 0; i < 4; i++) step(2'b11, 2'b01, 2'b01, "m0_lock_hold");
    step(2'b10, 2'b00, 2'b10, "handover_m1");
    for (int i = 0; i < 2; i++) step(2'b10, 2'b10, 2'b10, "m1_lock_hold");
    step(2'b00, 2'b00, 2'b00, "release_idle");

    step(2'b11, 2'b00, 2'b01, "fair_0");
    step(2'b11, 2'b00, 2'b10, "fair_1");
    step(2'b11, 2'b00, 2'b01, "fair_2");

    step(2'b11, 2'b10, 2'b10, "ignored_lock");
    step(2'b10, 2'b10, 2'b10, "m1_locked");
    reset_pulse("rst_mid_lock");
    step(2'b11, 2'b00, 2'b01, "after_reset");

    step(2'b01, 2'b00, 2'b01, "sole_hold");
    step(2'b00, 2'b10, 2'b00, "release_nonowner_lock");
    step(2'b01, 2'b00, 2'b01, "m0_again");
    reset_pulse("rst_unlocked");
    step(2'b11, 2'b00, 2'b01, "ptr_reset_prio0");
    step(2'b11, 2'b01, 2'b01, "lock_beats_other");
    step(2'b10, 2'b01, 2'b10, "drop_with_lock_high");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain observed %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_arbiter.md
SLAVE_ARBITER -- requirements
Module: slave_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of requesting masters, legal range 2..16.
REQ-002 Derived constant SEL_W = clog2(NUM_MASTERS+1): width of o_MuxSel (2 when NUM_MASTERS=2).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 i_Clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_Rst  input  1  asynchronous active-high reset.
REQ-006 i_Req  input  NUM_MASTERS  per-master request; bit k belongs to master k.
REQ-007 i_Lock  input  NUM_MASTERS  per-master lock; holds the grant while that master owns the slave.
REQ-008 o_Gnt  output  NUM_MASTERS  registered grant, one-hot or all-zero.
REQ-009 o_MuxSel  output  SEL_W  registered slave-side mux select: 0 = no owner, k+1 = master k owns.

Function
REQ-010 The block SHALL hold an owner register (valid flag plus index); o_Gnt and o_MuxSel SHALL decode only from it, with no combinational path from inputs to outputs.
REQ-011 No owner, any i_Req bit high at a rising edge: the block SHALL grant the round-robin winner at that edge, so o_Gnt rises 1 cycle after i_Req is sampled.
REQ-012 Round-robin order SHALL start at index (last owner + 1) mod NUM_MASTERS and scan upward with wrap-around; after reset, master 0 has highest priority.
REQ-013 Owner with i_Req high and i_Lock high: the grant SHALL be held regardless of other requests.
REQ-014 Owner with i_Req high, i_Lock low, and no other request: the grant SHALL be held.
REQ-015 Owner with i_Req high, i_Lock low, and another master requesting: the block SHALL hand the grant to the round-robin winner among the other requesters at that edge.
REQ-016 Owner with i_Req low (its i_Lock ignored): the block SHALL release at that edge and grant the round-robin winner among the remaining requesters in the same edge, with no idle cycle; with no requesters, o_Gnt = 0 and o_MuxSel = 0.
REQ-017 i_Lock bits of non-owners SHALL be ignored.
REQ-018 Simultaneous first requests SHALL be resolved by REQ-012; the loser keeps i_Req high and SHALL be granted on the edge the owner releases.
REQ-019 At most one o_Gnt bit SHALL be high in any cycle; o_MuxSel SHALL always equal the encoded o_Gnt.
REQ-020 The round-robin pointer SHALL update only when a new owner is granted.

Reset
REQ-021 i_Rst high SHALL asynchronously clear the owner-valid flag, giving o_Gnt = 0 and o_MuxSel = 0, and SHALL set the pointer so master 0 has highest priority.
REQ-022 Reset asserted mid-ownership SHALL drop the grant immediately, locked or not.
REQ-023 After reset deasserts, the first arbitration SHALL occur at the next rising edge.

Structure
REQ-024 SEL_W derivation and a clog2 helper SHALL live in shared package xbar_pkg, for reuse by the crossbar mux.
REQ-025 One sub-module, rr_pick, SHALL implement the combinational round-robin selector: inputs are the request vector and the start index; outputs are a valid flag and the winner index.
REQ-026 slave_arbiter SHALL contain only the owner/pointer registers, the hold/release decision, and output decode.

Verification (NUM_MASTERS=2)
REQ-027 Reset: i_Rst=1 -> o_Gnt=2'b00 and o_MuxSel=0 immediately, with no clock edge required.
REQ-028 Simultaneous start: i_Req=2'b11 at the same edge -> o_Gnt=2'b01 and o_MuxSel=1 one cycle later; master 0 then sets i_Lock[0]=1 and holds 4 cycles -> o_Gnt stays 2'b01.
REQ-029 Handover: master 0 drops i_Req[0] and i_Lock[0] while i_Req[1]=1 -> next edge o_Gnt=2'b10 and o_MuxSel=2, with no idle cycle; master 1 locks 2 cycles, then drops i_Req[1] -> o_Gnt=2'b00 and o_MuxSel=0.
REQ-030 Fairness: both masters request with locks low -> grant alternates 2'b01, 2'b10, 2'b01 on successive edges.
REQ-031 Ignored lock: i_Lock[1]=1 while master 0 owns and i_Lock[0]=0, with i_Req=2'b11 -> grant moves to master 1 at the next edge.
REQ-032 Reset mid-lock: i_Rst pulsed while o_Gnt=2'b10 and locked -> o_Gnt=0 immediately; with i_Req=2'b11 after release -> o_Gnt=2'b01.
